// File: rtl/servo_pkg.sv
// ============================================================================
// servo_pkg : shared constants, register map and FSM states for servo_ramp_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

   localparam int NCH = 8;

   localparam logic [7:0] E_OFF  = 8'd0;
   localparam logic [7:0] T_OFF  = 8'd4;
   localparam logic [7:0] D_OFF  = 8'd8;
   localparam logic [7:0] STRIDE = 8'd12;

   typedef enum logic [2:0] {
      INIT_T = 3'd0,
      INIT_D = 3'd1,
      INIT_E = 3'd2,
      IDLE   = 3'd3,
      SWEEP  = 3'd4
   } state_t;

   function automatic logic [7:0] reg_addr(input logic [2:0] ch, input logic [7:0] off);
      return ({5'd0, ch} * STRIDE) + off;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : free-running divider producing a one-cycle tick every TICK_DIV clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] r_cnt;

   assign tick = (r_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/servo_ramp_ctrl.sv
// ============================================================================
// servo_ramp_ctrl : initialises the 8-channel PWM peripheral, then ramps each
// channel's duty toward its commanded target once per tick. Rev 1.0
// ============================================================================
`default_nettype none

module servo_ramp_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50000,
   parameter logic [31:0] PERIOD    = 32'd1000000,
   parameter logic [31:0] DUTY_INIT = 32'd75000,
   parameter logic [31:0] DUTY_MIN  = 32'd50000,
   parameter logic [31:0] DUTY_MAX  = 32'd100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_ch,
   input  logic [31:0] cmd_target,
   input  logic [15:0] cmd_step,
   output logic        pwm_cs,
   output logic        pwm_wr,
   output logic        pwm_rd,
   output logic [7:0]  pwm_addr,
   output logic [31:0] pwm_d,
   output logic        busy,
   output logic [7:0]  ch_moving,
   output logic        all_done
);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_idx, w_idx_nxt;
   logic        r_cs, w_cs_nxt;
   logic [7:0]  r_addr, w_addr_nxt;
   logic [31:0] r_d, w_d_nxt;
   logic        w_upd;

   logic [31:0] r_cur  [NCH];
   logic [31:0] r_tgt  [NCH];
   logic [15:0] r_step [NCH];

   logic        w_tick;
   logic        w_cmd_acc;
   logic [31:0] w_clamped;
   logic [31:0] w_cur, w_tgt, w_stp, w_diff, w_next;
   logic        w_last;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign pwm_cs    = r_cs;
   assign pwm_wr    = r_cs;
   assign pwm_rd    = 1'b0;
   assign pwm_addr  = r_addr;
   assign pwm_d     = r_d;
   assign busy      = (r_state != IDLE);
   assign cmd_ready = (r_state == IDLE) || (r_state == SWEEP);
   assign all_done  = ~|ch_moving;
   assign w_cmd_acc = cmd_valid && cmd_ready;
   assign w_last    = (r_idx == 3'(NCH - 1));

   for (genvar i = 0; i < NCH; i++) begin : g_moving
      assign ch_moving[i] = (r_cur[i] != r_tgt[i]);
   end

   always_comb begin
      w_clamped = cmd_target;
      if (cmd_target < DUTY_MIN) begin
         w_clamped = DUTY_MIN;
      end else if (cmd_target > DUTY_MAX) begin
         w_clamped = DUTY_MAX;
      end
   end

   // Step toward the target without ever crossing it; step 0 means jump.
   always_comb begin
      w_cur  = r_cur[r_idx];
      w_tgt  = r_tgt[r_idx];
      w_stp  = {16'd0, r_step[r_idx]};
      w_diff = (w_cur > w_tgt) ? (w_cur - w_tgt) : (w_tgt - w_cur);
      w_next = w_tgt;
      if ((w_stp != 32'd0) && (w_diff > w_stp)) begin
         w_next = (w_cur > w_tgt) ? (w_cur - w_stp) : (w_cur + w_stp);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cs_nxt    = 1'b0;
      w_addr_nxt  = 8'd0;
      w_d_nxt     = 32'd0;
      w_upd       = 1'b0;
      case (r_state)
         INIT_T: begin
            w_cs_nxt   = 1'b1;
            w_addr_nxt = reg_addr(r_idx, T_OFF);
            w_d_nxt    = PERIOD;
            w_idx_nxt  = r_idx + 3'd1;
            if (w_last) w_state_nxt = INIT_D;
         end
         INIT_D: begin
            w_cs_nxt   = 1'b1;
            w_addr_nxt = reg_addr(r_idx, D_OFF);
            w_d_nxt    = DUTY_INIT;
            w_idx_nxt  = r_idx + 3'd1;
            if (w_last) w_state_nxt = INIT_E;
         end
         INIT_E: begin
            w_cs_nxt   = 1'b1;
            w_addr_nxt = reg_addr(r_idx, E_OFF);
            w_d_nxt    = 32'd1;
            w_idx_nxt  = r_idx + 3'd1;
            if (w_last) w_state_nxt = IDLE;
         end
         IDLE: begin
            w_idx_nxt = 3'd0;
            if (w_tick) w_state_nxt = SWEEP;
         end
         SWEEP: begin
            if (w_cur != w_tgt) begin
               w_cs_nxt   = 1'b1;
               w_addr_nxt = reg_addr(r_idx, D_OFF);
               w_d_nxt    = w_next;
               w_upd      = 1'b1;
            end
            w_idx_nxt = r_idx + 3'd1;
            if (w_last) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = INIT_T;
            w_idx_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT_T;
         r_idx   <= 3'd0;
         r_cs    <= 1'b0;
         r_addr  <= 8'd0;
         r_d     <= 32'd0;
         for (int i = 0; i < NCH; i++) begin
            r_cur[i]  <= DUTY_INIT;
            r_tgt[i]  <= DUTY_INIT;
            r_step[i] <= 16'd0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cs    <= w_cs_nxt;
         r_addr  <= w_addr_nxt;
         r_d     <= w_d_nxt;
         if (w_upd) r_cur[r_idx] <= w_next;
         // The sweep above read the old tgt/step, so a same-cycle command waits a tick.
         if (w_cmd_acc) begin
            r_tgt[cmd_ch]  <= w_clamped;
            r_step[cmd_ch] <= cmd_step;
         end
      end
   end

endmodule

`default_nettype wire
